// File: rtl/execute_writeback_stage.sv
// rtl/execute_writeback_stage.sv - CPU execute stage: shift, ALU, ZNV flags, registered writeback.
// Optional EXEC_FORWARD_EN: bypass registered wb_data into same-cycle A/B operands.
module execute_writeback_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        stall,
    input  logic [15:0] A_in,
    input  logic [15:0] B_in,
    input  logic [15:0] sximm5_in,
    input  logic [15:0] sximm8_in,
    input  logic [15:0] pc_in,
    input  logic [15:0] mdata_in,
    input  logic [1:0]  shift,
    input  logic [1:0]  ALUop,
    input  logic        asel,
    input  logic        bsel,
    input  logic        loads,
    input  logic [1:0]  vsel_in,
    input  logic [2:0]  write_num_in,
    input  logic        write_in,
    input  logic [2:0]  rs_a_num,
    input  logic [2:0]  rs_b_num,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_num,
    output logic        wb_write,
    output logic        valid_out,
    output logic        Z,
    output logic        N,
    output logic        V
);

    logic [15:0] a_op;
    logic [15:0] b_op;
    logic [15:0] b_sh;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [15:0] alu_c;
    logic [15:0] wb_mux;
    logic        alu_v;

`ifdef EXEC_FORWARD_EN
    // Bypass only a result that will really reach the register file.
    always_comb begin
        a_op = A_in;
        b_op = B_in;
        if (valid_out && wb_write && (wb_num == rs_a_num))
            a_op = wb_data;
        if (valid_out && wb_write && (wb_num == rs_b_num))
            b_op = wb_data;
    end
`else
    logic unused_rs_nums;
    assign unused_rs_nums = ^{rs_a_num, rs_b_num};

    always_comb begin
        a_op = A_in;
        b_op = B_in;
    end
`endif

    always_comb begin
        case (shift)
            2'b00:   b_sh = b_op;
            2'b01:   b_sh = {b_op[14:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_op[15:1]};
            default: b_sh = {b_op[15], b_op[15:1]};
        endcase

        ain = asel ? 16'h0000 : a_op;
        bin = bsel ? sximm5_in : b_sh;

        alu_v = 1'b0;
        case (ALUop)
            2'b00: begin
                alu_c = ain + bin;
                alu_v = (ain[15] == bin[15]) && (alu_c[15] != ain[15]);
            end
            2'b01: begin
                alu_c = ain - bin;
                alu_v = (ain[15] != bin[15]) && (alu_c[15] != ain[15]);
            end
            2'b10:   alu_c = ain & bin;
            default: alu_c = ~bin;
        endcase

        case (vsel_in)
            2'b00:   wb_mux = alu_c;
            2'b01:   wb_mux = sximm8_in;
            2'b10:   wb_mux = pc_in;
            default: wb_mux = mdata_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data   <= 16'h0000;
            wb_num    <= 3'd0;
            wb_write  <= 1'b0;
            valid_out <= 1'b0;
            Z         <= 1'b0;
            N         <= 1'b0;
            V         <= 1'b0;
        end else if (!stall) begin
            valid_out <= valid_in;
            wb_data   <= wb_mux;
            wb_num    <= write_num_in;
            wb_write  <= write_in & valid_in;
            // Bubbles must never disturb the flags of the last real instruction.
            if (loads && valid_in) begin
                Z <= (alu_c == 16'h0000);
                N <= alu_c[15];
                V <= alu_v;
            end
        end
    end

endmodule

// File: tb/tb_execute_writeback_stage.sv
// tb/tb_execute_writeback_stage.sv - randomized + directed check of execute_writeback_stage against a behavioural model.
module tb_execute_writeback_stage;

    logic        clk = 1'b0;
    logic        reset, valid_in, stall;
    logic [15:0] A_in, B_in, sximm5_in, sximm8_in, pc_in, mdata_in;
    logic [1:0]  shift, ALUop, vsel_in;
    logic        asel, bsel, loads, write_in;
    logic [2:0]  write_num_in, rs_a_num, rs_b_num;
    logic [15:0] wb_data;
    logic [2:0]  wb_num;
    logic        wb_write, valid_out, Z, N, V;

    always #5 clk = ~clk;

    execute_writeback_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall),
        .A_in(A_in), .B_in(B_in), .sximm5_in(sximm5_in), .sximm8_in(sximm8_in),
        .pc_in(pc_in), .mdata_in(mdata_in), .shift(shift), .ALUop(ALUop),
        .asel(asel), .bsel(bsel), .loads(loads), .vsel_in(vsel_in),
        .write_num_in(write_num_in), .write_in(write_in),
        .rs_a_num(rs_a_num), .rs_b_num(rs_b_num),
        .wb_data(wb_data), .wb_num(wb_num), .wb_write(wb_write),
        .valid_out(valid_out), .Z(Z), .N(N), .V(V)
    );

    // Packed view: {data[23:8], num[7:5], write[4], valid[3], Z[2], N[1], V[0]}
    localparam logic [23:0] M_DATA = 24'hFFFF00;
    localparam logic [23:0] M_WR   = 24'h000010;
    localparam logic [23:0] M_VAL  = 24'h000008;
    localparam logic [23:0] M_FLG  = 24'h000007;
    localparam logic [23:0] M_ALL  = 24'hFFFFFF;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    logic [15:0] m_data;
    logic [2:0]  m_num;
    logic        m_wr, m_val, m_z, m_n, m_v;
    logic [15:0] n_data;
    logic [2:0]  n_num;
    logic        n_wr, n_val, n_z, n_n, n_v;

    logic        lit_on = 1'b0;
    string       lit_name;
    logic [23:0] lit_mask, lit_val;

    function automatic logic [23:0] pack(input logic [15:0] d, input logic [2:0] num,
                                         input logic wr, input logic vl,
                                         input logic z, input logic n, input logic v);
        return {d, num, wr, vl, z, n, v};
    endfunction

    task automatic model_step();
        logic [15:0] a, b, bsh, ain, bin, c, mux;
        int sa, sb, r;
        logic v;
        if (reset) begin
            n_data = 0; n_num = 0; n_wr = 0; n_val = 0; n_z = 0; n_n = 0; n_v = 0;
        end else if (stall) begin
            n_data = m_data; n_num = m_num; n_wr = m_wr; n_val = m_val;
            n_z = m_z; n_n = m_n; n_v = m_v;
        end else begin
            a = A_in;
            b = B_in;
`ifdef EXEC_FORWARD_EN
            if (m_val && m_wr && m_num == rs_a_num) a = m_data;
            if (m_val && m_wr && m_num == rs_b_num) b = m_data;
`endif
            sb = int'($signed(b));
            case (shift)
                2'd0: bsh = b;
                2'd1: bsh = 16'((int'(b) * 2) % 65536);
                2'd2: bsh = 16'(int'(b) / 2);
                default: bsh = 16'((sb - (sb & 1)) / 2);
            endcase
            ain = asel ? 16'd0 : a;
            bin = bsel ? sximm5_in : bsh;
            sa = int'($signed(ain));
            sb = int'($signed(bin));
            v = 1'b0;
            case (ALUop)
                2'd0: begin r = sa + sb; c = 16'(r); v = (r > 32767) || (r < -32768); end
                2'd1: begin r = sa - sb; c = 16'(r); v = (r > 32767) || (r < -32768); end
                2'd2: c = ain & bin;
                default: c = 16'hFFFF - bin;
            endcase
            case (vsel_in)
                2'd0: mux = c;
                2'd1: mux = sximm8_in;
                2'd2: mux = pc_in;
                default: mux = mdata_in;
            endcase
            n_data = mux; n_num = write_num_in; n_wr = write_in && valid_in; n_val = valid_in;
            if (loads && valid_in) begin
                n_z = (c == 0); n_n = (sa + 0 < 0) ? c[15] : c[15]; n_v = v;
                n_n = (int'($signed(c)) < 0);
            end else begin
                n_z = m_z; n_n = m_n; n_v = m_v;
            end
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (pack(wb_data, wb_num, wb_write, valid_out, Z, N, V) !==
                pack(m_data, m_num, m_wr, m_val, m_z, m_n, m_v)) begin
                errors++;
                $display("FAIL model_state t=%0t got %h expected %h", $time,
                         pack(wb_data, wb_num, wb_write, valid_out, Z, N, V),
                         pack(m_data, m_num, m_wr, m_val, m_z, m_n, m_v));
            end
            if (lit_on) begin
                checks++;
                if ((pack(wb_data, wb_num, wb_write, valid_out, Z, N, V) & lit_mask) !== lit_val) begin
                    errors++;
                    $display("FAIL %s got %h expected %h (mask %h)", lit_name,
                             pack(wb_data, wb_num, wb_write, valid_out, Z, N, V) & lit_mask,
                             lit_val, lit_mask);
                end
            end
        end
    end

    task automatic cycle();
        model_step();
        @(posedge clk);
        m_data = n_data; m_num = n_num; m_wr = n_wr; m_val = n_val;
        m_z = n_z; m_n = n_n; m_v = n_v;
        @(negedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    task automatic expect_lit(input string name, input logic [23:0] mask, input logic [23:0] val);
        lit_name = name;
        lit_mask = mask;
        lit_val  = val & mask;
        lit_on   = 1'b1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; valid_in = 1;
        A_in = 0; B_in = 0; sximm5_in = 0; sximm8_in = 0; pc_in = 0; mdata_in = 0;
        shift = 0; ALUop = 0; asel = 0; bsel = 0; loads = 0; vsel_in = 0;
        write_num_in = 3'd4; write_in = 0; rs_a_num = 0; rs_b_num = 0;
    endtask

    function automatic logic [15:0] rnd16();
        logic [15:0] corners [5];
        corners = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    task automatic randomize_inputs();
        reset = ($urandom_range(0, 31) == 0);
        stall = ($urandom_range(0, 4) == 0);
        valid_in = ($urandom_range(0, 4) != 0);
        A_in = rnd16(); B_in = rnd16(); sximm5_in = rnd16(); sximm8_in = rnd16();
        pc_in = rnd16(); mdata_in = rnd16();
        shift = 2'($urandom); ALUop = 2'($urandom); vsel_in = 2'($urandom);
        asel = ($urandom_range(0, 3) == 0); bsel = ($urandom_range(0, 3) == 0);
        loads = 1'($urandom); write_in = 1'($urandom);
        write_num_in = 3'($urandom); rs_a_num = 3'($urandom); rs_b_num = 3'($urandom);
    endtask

    initial begin
        idle();
        reset = 1; A_in = 16'hBEEF; B_in = 16'h1234; loads = 1; write_in = 1;
        check_en = 1'b1;
        expect_lit("reset_clear", M_ALL, pack(16'h0, 3'd0, 0, 0, 0, 0, 0));
        cycle();

        idle(); A_in = 16'h7FFF; B_in = 16'h0001; loads = 1; write_in = 1; write_num_in = 3'd2;
        expect_lit("add_overflow", M_ALL, pack(16'h8000, 3'd2, 1, 1, 0, 1, 1));
        cycle();

        idle(); reset = 1; stall = 1; A_in = 16'h5555; loads = 1; write_in = 1;
        expect_lit("reset_over_stall", M_ALL, pack(16'h0, 3'd0, 0, 0, 0, 0, 0));
        cycle();

        idle(); A_in = 16'h7FFF; B_in = 16'h0001; loads = 1; write_in = 1; write_num_in = 3'd2;
        cycle();
        idle(); A_in = 16'h1234; B_in = 16'h1234; ALUop = 2'b01; loads = 1; write_in = 0;
        expect_lit("cmp_equal", M_DATA | M_WR | M_FLG, pack(16'h0, 3'd0, 0, 0, 1, 0, 0));
        cycle();

        idle(); B_in = 16'h8002; shift = 2'b11; ALUop = 2'b11; write_in = 1; write_num_in = 3'd3;
        expect_lit("asr_mvn", M_DATA | M_FLG, pack(16'h3FFE, 3'd0, 0, 0, 1, 0, 0));
        cycle();

        idle(); A_in = 16'h0005; bsel = 1; sximm5_in = 16'hFFFF; write_in = 1; write_num_in = 3'd3;
        expect_lit("add_sximm5", M_DATA | M_WR, pack(16'h0004, 3'd0, 1, 0, 0, 0, 0));
        cycle();

        for (int i = 0; i < 2; i++) begin
            idle(); stall = 1; A_in = 16'h4000; B_in = 16'h4000; loads = 1; write_in = 1;
            vsel_in = 2'b10; pc_in = 16'hABCD;
            expect_lit("stall_hold", M_DATA | M_FLG, pack(16'h0004, 3'd0, 0, 0, 1, 0, 0));
            cycle();
        end

        idle(); valid_in = 0; A_in = 16'h7FFF; B_in = 16'h0001; loads = 1; write_in = 1;
        expect_lit("bubble", M_WR | M_VAL | M_FLG, pack(16'h0, 3'd0, 0, 0, 1, 0, 0));
        cycle();

        idle(); vsel_in = 2'b01; sximm8_in = 16'd7; write_num_in = 3'd1; write_in = 1;
        expect_lit("mov_r1_7", M_DATA | M_WR, pack(16'd7, 3'd0, 1, 0, 0, 0, 0));
        cycle();

        idle(); A_in = 16'd0; B_in = 16'd3; rs_a_num = 3'd1; rs_b_num = 3'd5;
        write_num_in = 3'd2; write_in = 1;
`ifdef EXEC_FORWARD_EN
        expect_lit("forward_a", M_DATA, pack(16'd10, 3'd0, 0, 0, 0, 0, 0));
`else
        expect_lit("no_forward_a", M_DATA, pack(16'd3, 3'd0, 0, 0, 0, 0, 0));
`endif
        cycle();

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
